// File: rtl/gamepad_io.sv
`default_nettype none
// ============================================================================
//  Module   : gamepad_io
//  Purpose  : NES-style controller interface. A free-running scanner clocks
//             two physical pads (shared latch/clock, active-low serial data)
//             into button registers. A CPU-side $4016/$4017 port set latches
//             those buttons into shift registers and returns one bit per read.
//  Ports    : CLK, RESET        - clock, synchronous active-high reset
//             port_sel          - CPU addr[0] (0: $4016, 1: $4017)
//             gamepad_w/_r      - CPU write / read strobes
//             wdata             - CPU write data (bit0 = strobe)
//             gamepad_data      - CPU read data (combinational)
//             pad1/pad2_data    - serial button data from pads, active-low
//             pad_latch/pad_clk - registered latch and clock to both pads
//             scan_done         - one-cycle pulse when new buttons commit
//  Revision : 1.0 - initial release
// ============================================================================
module gamepad_io #(
  parameter int SCAN_PERIOD  = 833333,
  parameter int PULSE_CYCLES = 300
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       port_sel,
  input  logic       gamepad_w,
  input  logic       gamepad_r,
  input  logic [7:0] wdata,
  output logic [7:0] gamepad_data,
  input  logic       pad1_data,
  input  logic       pad2_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic       scan_done
);

  localparam int CNT_MAX = (SCAN_PERIOD > PULSE_CYCLES) ? SCAN_PERIOD : PULSE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_PERIOD - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LATCH  = 2'd1;
  localparam logic [1:0] S_CLK_LO = 2'd2;
  localparam logic [1:0] S_CLK_HI = 2'd3;

  // --------------------------------------------------------------------------
  // Scanner
  // --------------------------------------------------------------------------
  logic [1:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]    r_idx,   w_idx_nxt;
  logic          w_sample;
  logic          w_commit;
  logic          w_latch_nxt, w_clk_nxt, w_done_nxt;

  logic [7:0]    r_shadow1, r_shadow2;
  logic [7:0]    w_shadow1_nxt, w_shadow2_nxt;
  logic [7:0]    r_btn1, r_btn2;

  // State register; pad outputs are registered from the next state so they
  // change only on clock edges and never glitch.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= 3'd0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      pad_latch <= w_latch_nxt;
      pad_clk   <= w_clk_nxt;
      scan_done <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_sample    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_cnt == SCAN_LAST) begin
          w_state_nxt = S_LATCH;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 3'd0;
        end
      end
      S_LATCH: begin
        if (r_cnt == PULSE_LAST) begin
          w_state_nxt = S_CLK_LO;
          w_cnt_nxt   = '0;
        end
      end
      S_CLK_LO: begin
        if (r_cnt == PULSE_LAST) begin
          // Sample at the end of the low phase: data has had a full
          // half-period to settle since the previous rising pad_clk.
          w_sample  = 1'b1;
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_IDLE;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = S_CLK_HI;
          end
        end
      end
      S_CLK_HI: begin
        if (r_cnt == PULSE_LAST) begin
          w_state_nxt = S_CLK_LO;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = 3'd0;
      end
    endcase
  end

  // Output logic (next-cycle values of the registered outputs)
  always_comb begin
    w_latch_nxt = (w_state_nxt == S_LATCH);
    w_clk_nxt   = (w_state_nxt == S_CLK_HI);
    w_done_nxt  = w_commit;
  end

  // Shadow with the bit currently being sampled merged in, so the commit
  // picks up bit 7 in the same cycle it is sampled.
  always_comb begin
    w_shadow1_nxt        = r_shadow1;
    w_shadow2_nxt        = r_shadow2;
    w_shadow1_nxt[r_idx] = ~pad1_data;
    w_shadow2_nxt[r_idx] = ~pad2_data;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_shadow1 <= 8'h00;
      r_shadow2 <= 8'h00;
      r_btn1    <= 8'h00;
      r_btn2    <= 8'h00;
    end else begin
      if (w_sample) begin
        r_shadow1 <= w_shadow1_nxt;
        r_shadow2 <= w_shadow2_nxt;
      end
      if (w_commit) begin
        r_btn1 <= w_shadow1_nxt;
        r_btn2 <= w_shadow2_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // CPU port
  // --------------------------------------------------------------------------
  logic       r_strobe;
  logic       r_prev;
  logic [7:0] r_sr1, r_sr2;
  logic       w_read_acc;
  logic       w_unused;

  // A held read strobe counts as a single access.
  assign w_read_acc = gamepad_r & ~r_prev;
  assign w_unused   = ^wdata[7:1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_strobe <= 1'b0;
      r_prev   <= 1'b0;
      r_sr1    <= 8'h00;
      r_sr2    <= 8'h00;
    end else begin
      r_prev <= gamepad_r;
      if (gamepad_w && !port_sel) begin
        r_strobe <= wdata[0];
      end
      // Reload uses the current strobe value, so the clearing write still
      // captures the latest buttons.
      if (r_strobe) begin
        r_sr1 <= r_btn1;
        r_sr2 <= r_btn2;
      end else if (w_read_acc) begin
        if (!port_sel) begin
          r_sr1 <= {1'b1, r_sr1[7:1]};
        end else begin
          r_sr2 <= {1'b1, r_sr2[7:1]};
        end
      end
    end
  end

  // Bit 6 mimics open-bus behaviour of the original console.
  assign gamepad_data = 8'h40 | {7'b0, (port_sel ? r_sr2[0] : r_sr1[0])};

endmodule
`default_nettype wire

// File: tb/tb_gamepad_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gamepad_io
//  Purpose  : Self-checking bench for gamepad_io with behavioural pad models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gamepad_io;

  localparam int SP       = 20;
  localparam int PC       = 2;
  // IDLE + LATCH + eight low phases + seven high phases
  localparam int SCAN_LEN = SP + PC + 15 * PC;

  logic       CLK       = 1'b0;
  logic       RESET     = 1'b1;
  logic       port_sel  = 1'b0;
  logic       gamepad_w = 1'b0;
  logic       gamepad_r = 1'b0;
  logic [7:0] wdata     = 8'h00;
  logic [7:0] gamepad_data;
  logic       pad1_data, pad2_data;
  logic       pad_latch, pad_clk, scan_done;

  int total = 0;
  int bad   = 0;

  // Physical controller model: latch loads buttons, each rising pad_clk
  // presents the next button; line is low when pressed.
  logic [7:0] pad_btn1 = 8'h00, pad_btn2 = 8'h00;
  logic [7:0] psr1 = 8'h00, psr2 = 8'h00;

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) begin
      psr1 <= pad_btn1;
      psr2 <= pad_btn2;
    end else begin
      psr1 <= {1'b0, psr1[7:1]};
      psr2 <= {1'b0, psr2[7:1]};
    end
  end
  assign pad1_data = ~psr1[0];
  assign pad2_data = ~psr2[0];

  gamepad_io #(.SCAN_PERIOD(SP), .PULSE_CYCLES(PC)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .port_sel     (port_sel),
    .gamepad_w    (gamepad_w),
    .gamepad_r    (gamepad_r),
    .wdata        (wdata),
    .gamepad_data (gamepad_data),
    .pad1_data    (pad1_data),
    .pad2_data    (pad2_data),
    .pad_latch    (pad_latch),
    .pad_clk      (pad_clk),
    .scan_done    (scan_done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       sel;
    logic       w;
    logic [7:0] wd;
    logic       r;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic w, input logic [7:0] d,
                              input logic r, input logic [7:0] e);
    vec_t v;
    v.sel = s; v.w = w; v.wd = d; v.r = r; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic w, input logic [7:0] d, input logic r);
    port_sel  = s;
    gamepad_w = w;
    wdata     = d;
    gamepad_r = r;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wait_scan(input string name);
    int n = 0;
    while (scan_done !== 1'b1 && n < 4 * SCAN_LEN) begin
      @(negedge CLK);
      n++;
    end
    chk(name, scan_done, 1);
  endtask

  // Reference model for randomized run: per-port read pointer into the
  // button snapshot taken while strobe was high, plus scan timing arithmetic.
  function automatic logic mbit(input int p, input logic [7:0] s);
    return (p >= 8) ? 1'b1 : s[p[2:0]];
  endfunction

  int         e, ph, p1, p2, first, n_lat, n_rise, n_hi, n_cyc;
  logic       ms, mp, prev_clk, got;
  logic [7:0] s1, s2, b1, b2, l1, l2;

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    chk("rst_data0", gamepad_data, 8'h40);
    port_sel = 1'b1;
    #1 chk("rst_data1", gamepad_data, 8'h40);
    port_sel = 1'b0;
    chk("rst_latch", pad_latch, 0);
    chk("rst_clk", pad_clk, 0);
    chk("rst_done", scan_done, 0);

    // ---------------- full scan waveform ----------------
    pad_btn1 = 8'h09;   // A + Start
    pad_btn2 = 8'h80;   // Right
    n_cyc = 0; n_lat = 0; n_rise = 0; n_hi = 0; prev_clk = 1'b0;
    while (scan_done !== 1'b1 && n_cyc < 200) begin
      @(negedge CLK);
      n_cyc++;
      n_lat += int'(pad_latch);
      n_hi  += int'(pad_clk);
      if (pad_clk && !prev_clk) n_rise++;
      prev_clk = pad_clk;
    end
    chk("scan_cycles", n_cyc, SCAN_LEN);
    chk("latch_width", n_lat, PC);
    chk("clk_pulses", n_rise, 7);
    chk("clk_high", n_hi, 7 * PC);

    // ---------------- table-driven CPU accesses ----------------
    vecs.push_back(mk(0, 1, 8'h01, 0, 8'h40));
    vecs.push_back(mk(0, 1, 8'h00, 0, 8'h40));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h41));  // read 1: A
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h40));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40));  // read 2: B
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h40));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40));  // read 3: Select
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h41));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h41));  // read 4: Start
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h40));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40));  // read 5
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h40));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40));  // read 6
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h40));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40));  // read 7
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h40));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40));  // read 8: Right
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h41));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h41));  // read 9
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h41));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h40));  // $4017 bit0 of 80
    vecs.push_back(mk(0, 1, 8'h01, 0, 8'h41));
    vecs.push_back(mk(0, 1, 8'h00, 0, 8'h41));
    vecs.push_back(mk(1, 1, 8'h01, 0, 8'h40));  // write $4017: ignored
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h41));  // read A, must shift
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h40));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40));
    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].w, vecs[i].wd, vecs[i].r);
      #1 chk($sformatf("vec%0d", i), gamepad_data, vecs[i].exp);
      @(negedge CLK);
    end

    // ---------------- held read: one shift per access ----------------
    drive(0, 1, 8'h01, 0); @(negedge CLK);
    drive(0, 1, 8'h00, 0); @(negedge CLK);
    drive(0, 0, 8'h00, 1);
    #1 chk("hold_first", gamepad_data, 8'h41);
    @(negedge CLK);
    repeat (4) begin
      #1 chk("hold_keep", gamepad_data, 8'h40);
      @(negedge CLK);
    end
    drive(0, 0, 8'h00, 0);
    #1 chk("hold_release", gamepad_data, 8'h40);
    @(negedge CLK);
    drive(0, 0, 8'h00, 1);
    #1 chk("hold_second", gamepad_data, 8'h40);
    @(negedge CLK);
    drive(0, 0, 8'h00, 0);

    // ---------------- strobe held while a scan commits ----------------
    drive(0, 1, 8'h01, 0); @(negedge CLK);
    drive(0, 0, 8'h00, 0);
    pad_btn1 = 8'h00;
    pad_btn2 = 8'h00;
    wait_scan("scan_zero_a"); @(negedge CLK);
    wait_scan("scan_zero_b"); @(negedge CLK);
    pad_btn1 = 8'h01;
    got = 1'b0;
    for (int k = 0; k < 4 * SCAN_LEN && !got; k++) begin
      if (scan_done === 1'b1) begin
        got = 1'b1;
      end else begin
        gamepad_r = k[0];
        #1 chk("strobe_read0", gamepad_data, 8'h40);
        @(negedge CLK);
      end
    end
    chk("commit_seen", got, 1);
    chk("commit_same", gamepad_data, 8'h40);
    @(negedge CLK);
    chk("commit_next", gamepad_data, 8'h41);
    drive(0, 0, 8'h00, 1);
    #1 chk("strobe_read1a", gamepad_data, 8'h41);
    @(negedge CLK);
    drive(0, 0, 8'h00, 0);
    #1 chk("strobe_read1b", gamepad_data, 8'h41);
    @(negedge CLK);

    // ---------------- reset during CLK_HI, index 3 ----------------
    pad_btn1 = 8'hFF;
    pad_btn2 = 8'hFF;
    do_reset();
    for (int n = 1; n <= SP + PC + 7 * PC; n++) @(negedge CLK);
    chk("hi3_clk", pad_clk, 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_clk", pad_clk, 0);
    chk("abort_latch", pad_latch, 0);
    chk("abort_done", scan_done, 0);
    RESET = 1'b0;
    drive(0, 1, 8'h01, 0);
    first = 0;
    for (int n = 1; n <= SCAN_LEN + 8; n++) begin
      @(negedge CLK);
      if (n == 1) drive(0, 0, 8'h00, 0);
      if (scan_done === 1'b1 && first == 0) first = n;
      if (n == 2) begin
        #1 chk("abort_btn1", gamepad_data, 8'h40);
        port_sel = 1'b1;
        #1 chk("abort_btn2", gamepad_data, 8'h40);
        port_sel = 1'b0;
      end
      if (first != 0 && n == first + 1) chk("rescan_load", gamepad_data, 8'h41);
    end
    chk("rescan_time", first, SCAN_LEN);

    // ---------------- randomized run against reference model ----------------
    do_reset();
    e = 0; ms = 1'b0; mp = 1'b0; p1 = 0; p2 = 0;
    s1 = 8'h00; s2 = 8'h00; b1 = 8'h00; b2 = 8'h00; l1 = 8'h00; l2 = 8'h00;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(39) == 0) pad_btn1 = 8'($urandom);
      if ($urandom_range(39) == 0) pad_btn2 = 8'($urandom);
      drive(1'($urandom_range(1)), ($urandom_range(7) == 0), 8'($urandom),
            1'($urandom_range(1)));
      #1;
      ph = e % SCAN_LEN;
      chk("rnd_data", gamepad_data,
          8'h40 | {7'b0, (port_sel ? mbit(p2, s2) : mbit(p1, s1))});
      chk("rnd_done", scan_done, (e > 0 && ph == 0));
      chk("rnd_latch", pad_latch, (ph >= SP && ph < SP + PC));
      chk("rnd_clk", pad_clk, (ph >= SP + PC && ((ph - SP - PC) / PC) % 2 == 1));
      @(posedge CLK);
      if (ms) begin
        s1 = b1; s2 = b2; p1 = 0; p2 = 0;
      end else if (gamepad_r && !mp) begin
        if (!port_sel) begin
          if (p1 < 8) p1++;
        end else begin
          if (p2 < 8) p2++;
        end
      end
      if (gamepad_w && !port_sel) ms = wdata[0];
      mp = gamepad_r;
      e++;
      if (e % SCAN_LEN == SP) begin
        l1 = pad_btn1; l2 = pad_btn2;
      end
      if (e % SCAN_LEN == 0) begin
        b1 = l1; b2 = l2;
      end
      @(negedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
